// File: rtl/adpcm_bus_pkg.sv
// Shared types and constants for the YM2610 ADPCM sample-ROM bus master.
//   state_t     : transaction sequencer states
//   BUS_SDR/SDP : request bus select encoding
//   bus_pins_t  : registered pin bundle for one bus (MPX, nOE, pad OE, upper address, AD)
//   drive_pins  : pin values for the selected bus in a given state
package adpcm_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        MPX_HI,
        ADDR_HI,
        MPX_LO,
        TURN,
        READ,
        DONE
    } state_t;

    localparam logic BUS_SDR = 1'b0;
    localparam logic BUS_SDP = 1'b1;

    localparam int SDR_HALF_W = 10;
    localparam int SDP_HALF_W = 12;

    typedef struct packed {
        logic       mpx;
        logic       n_oe;
        logic       pad_oe;
        logic [3:0] a;
        logic [7:0] ad;
    } bus_pins_t;

    localparam bus_pins_t PINS_IDLE = '{mpx: 1'b0, n_oe: 1'b1, pad_oe: 1'b0, a: 4'h0, ad: 8'h00};

    // half is the address half currently on the bus, zero-extended to 12 bits.
    // The half is held through TURN/READ/DONE so the pads never glitch
    // between the address phase and the read.
    function automatic bus_pins_t drive_pins(state_t st, logic [11:0] half);
        bus_pins_t p;
        p = PINS_IDLE;
        if (st != IDLE) begin
            p.mpx    = (st == MPX_HI) || (st == ADDR_HI);
            p.n_oe   = (st != READ);
            p.pad_oe = (st == ADDR_LO) || (st == MPX_HI) || (st == ADDR_HI) || (st == MPX_LO);
            p.a      = half[11:8];
            p.ad     = half[7:0];
        end
        return p;
    endfunction

endpackage

// File: rtl/adpcm_phase_cnt.sv
// Loadable 4-bit down-counter shared by all timed sequencer states.
//   clk, reset : clock and synchronous active-high reset
//   load       : reload with load_val (asserted on state entry)
//   load_val   : cycles-in-state minus one
//   zero       : count has reached zero (last cycle of the state)
module adpcm_phase_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/adpcm_bus_master.sv
// YM2610 ADPCM sample-ROM bus initiator. Takes one 24-bit byte-read request,
// drives it as two multiplexed address halves with MPX strobes on either the
// ADPCM-A (SDR) or ADPCM-B (SDP) bus, then pulses the read enable and returns
// the captured byte.
//   CLK, RESET                      : clock, synchronous active-high reset
//   REQ_VALID/READY/BUS/ADDR        : request handshake (READY only in IDLE)
//   RSP_VALID, RSP_DATA             : one-cycle response pulse, data held
//   SDRAD_O/_I/_OE, SDRA_L, SDRA_U  : SDR address/data pads and upper address
//   SDRMPX, nSDROE                  : SDR strobe and read enable
//   SDPAD_O/_I/_OE, SDPA            : SDP address/data pads and upper address
//   SDPMPX, nSDPOE                  : SDP strobe and read enable
module adpcm_bus_master #(
    parameter int PHASE_CYC = 2,
    parameter int OE_CYC    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_BUS,
    input  logic [23:0] REQ_ADDR,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_DATA,
    output logic [7:0]  SDRAD_O,
    input  logic [7:0]  SDRAD_I,
    output logic        SDRAD_OE,
    output logic [1:0]  SDRA_L,
    output logic [3:0]  SDRA_U,
    output logic        SDRMPX,
    output logic        nSDROE,
    output logic [7:0]  SDPAD_O,
    input  logic [7:0]  SDPAD_I,
    output logic        SDPAD_OE,
    output logic [3:0]  SDPA,
    output logic        SDPMPX,
    output logic        nSDPOE
);

    import adpcm_bus_pkg::*;

    if (PHASE_CYC < 1 || PHASE_CYC > 15) begin : g_bad_phase_cyc
        $error("adpcm_bus_master: PHASE_CYC must be in 1..15");
    end
    if (OE_CYC < 1 || OE_CYC > 15) begin : g_bad_oe_cyc
        $error("adpcm_bus_master: OE_CYC must be in 1..15");
    end

    localparam logic [3:0] PHASE_LOAD = 4'(PHASE_CYC - 1);
    localparam logic [3:0] OE_LOAD    = 4'(OE_CYC - 1);

    state_t      state, state_nx;
    logic        bus_q, bus_nx;
    logic [23:0] addr_q, addr_nx;
    logic        accept;
    logic        cnt_load, cnt_zero;
    logic [3:0]  cnt_val;
    logic        lo_phase;
    logic [11:0] half_nx;
    bus_pins_t   sel_pins;
    bus_pins_t   sdr_q, sdp_q;
    logic [3:0]  sdra_u_q;
    logic        sdr_a_unused;

    assign accept  = (state == IDLE) && REQ_READY && REQ_VALID;
    assign bus_nx  = accept ? REQ_BUS  : bus_q;
    assign addr_nx = accept ? REQ_ADDR : addr_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)   state_nx = ADDR_LO;
            ADDR_LO: if (cnt_zero) state_nx = MPX_HI;
            MPX_HI:  if (cnt_zero) state_nx = ADDR_HI;
            ADDR_HI: if (cnt_zero) state_nx = MPX_LO;
            MPX_LO:  if (cnt_zero) state_nx = TURN;
            TURN:                  state_nx = READ;
            READ:    if (cnt_zero) state_nx = DONE;
            DONE:                  state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    // Reloading on every state change keeps the untimed states harmless:
    // whatever they load is overwritten on entry to the next timed state.
    assign cnt_load = (state_nx != state);
    assign cnt_val  = (state_nx == READ) ? OE_LOAD : PHASE_LOAD;

    adpcm_phase_cnt u_phase_cnt (
        .clk      (CLK),
        .reset    (RESET),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Pin values are computed from the next state so every pin is a flop
    // that changes together with the state register.
    always_comb begin
        lo_phase = (state_nx == ADDR_LO) || (state_nx == MPX_HI);
        if (bus_nx == BUS_SDR) begin
            half_nx = lo_phase ? 12'(addr_nx[SDR_HALF_W-1:0])
                               : 12'(addr_nx[2*SDR_HALF_W-1:SDR_HALF_W]);
        end else begin
            half_nx = lo_phase ? addr_nx[SDP_HALF_W-1:0]
                               : addr_nx[2*SDP_HALF_W-1:SDP_HALF_W];
        end
        sel_pins = drive_pins(state_nx, half_nx);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            bus_q     <= BUS_SDR;
            addr_q    <= 24'h0;
            sdr_q     <= PINS_IDLE;
            sdp_q     <= PINS_IDLE;
            sdra_u_q  <= 4'h0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= 8'h00;
        end else begin
            state     <= state_nx;
            bus_q     <= bus_nx;
            addr_q    <= addr_nx;
            sdr_q     <= (bus_nx == BUS_SDR) ? sel_pins : PINS_IDLE;
            sdp_q     <= (bus_nx == BUS_SDP) ? sel_pins : PINS_IDLE;
            sdra_u_q  <= ((bus_nx == BUS_SDR) && (state_nx != IDLE)) ? addr_nx[23:20] : 4'h0;
            REQ_READY <= (state_nx == IDLE);
            RSP_VALID <= (state_nx == DONE);
            if ((state == READ) && cnt_zero) begin
                RSP_DATA <= (bus_q == BUS_SDP) ? SDPAD_I : SDRAD_I;
            end
        end
    end

    assign SDRMPX   = sdr_q.mpx;
    assign nSDROE   = sdr_q.n_oe;
    assign SDRAD_OE = sdr_q.pad_oe;
    assign SDRAD_O  = sdr_q.ad;
    assign SDRA_L   = sdr_q.a[1:0];
    assign SDRA_U   = sdra_u_q;

    // The SDR half is only 10 bits wide, so the top of its upper-address field is always zero.
    assign sdr_a_unused = ^sdr_q.a[3:2];

    assign SDPMPX   = sdp_q.mpx;
    assign nSDPOE   = sdp_q.n_oe;
    assign SDPAD_OE = sdp_q.pad_oe;
    assign SDPAD_O  = sdp_q.ad;
    assign SDPA     = sdp_q.a;

endmodule

// File: tb/tb_adpcm_bus_master.sv
// Self-checking bench for adpcm_bus_master: default-timing instance plus a
// PHASE_CYC=1/OE_CYC=1 instance, directed vectors with hand-computed results.
module tb_adpcm_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid1 = 1'b0;
    logic        req_bus = 1'b0;
    logic [23:0] req_addr = 24'h0;
    logic [7:0]  sdrad_i = 8'h00;
    logic [7:0]  sdpad_i = 8'h00;

    logic        req_ready, rsp_valid, sdrad_oe, sdrmpx, nsdroe, sdpad_oe, sdpmpx, nsdpoe;
    logic [7:0]  rsp_data, sdrad_o, sdpad_o;
    logic [1:0]  sdra_l;
    logic [3:0]  sdra_u, sdpa;

    logic        req_ready1, rsp_valid1, sdrad_oe1, sdrmpx1, nsdroe1, sdpad_oe1, sdpmpx1, nsdpoe1;
    logic [7:0]  rsp_data1, sdrad_o1, sdpad_o1;
    logic [1:0]  sdra_l1;
    logic [3:0]  sdra_u1, sdpa1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adpcm_bus_master #(.PHASE_CYC(2), .OE_CYC(4)) dut (
        .CLK(clk), .RESET(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_BUS(req_bus), .REQ_ADDR(req_addr),
        .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
        .SDRAD_O(sdrad_o), .SDRAD_I(sdrad_i), .SDRAD_OE(sdrad_oe), .SDRA_L(sdra_l),
        .SDRA_U(sdra_u), .SDRMPX(sdrmpx), .nSDROE(nsdroe),
        .SDPAD_O(sdpad_o), .SDPAD_I(sdpad_i), .SDPAD_OE(sdpad_oe), .SDPA(sdpa),
        .SDPMPX(sdpmpx), .nSDPOE(nsdpoe)
    );

    adpcm_bus_master #(.PHASE_CYC(1), .OE_CYC(1)) dut1 (
        .CLK(clk), .RESET(rst),
        .REQ_VALID(req_valid1), .REQ_READY(req_ready1), .REQ_BUS(req_bus), .REQ_ADDR(req_addr),
        .RSP_VALID(rsp_valid1), .RSP_DATA(rsp_data1),
        .SDRAD_O(sdrad_o1), .SDRAD_I(sdrad_i), .SDRAD_OE(sdrad_oe1), .SDRA_L(sdra_l1),
        .SDRA_U(sdra_u1), .SDRMPX(sdrmpx1), .nSDROE(nsdroe1),
        .SDPAD_O(sdpad_o1), .SDPAD_I(sdpad_i), .SDPAD_OE(sdpad_oe1), .SDPA(sdpa1),
        .SDPMPX(sdpmpx1), .nSDPOE(nsdpoe1)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor: invariants and reference demultiplexer ----------------
    logic        mon_en = 1'b0;
    logic        sel_chk_en = 1'b0;
    logic        cur_bus = 1'b0;
    int          sdr_lo = -1, sdr_hi = -1, sdp_lo = -1, sdp_hi = -1, sdp1_lo = -1, sdp1_hi = -1;
    logic        p_sdrmpx = 1'b0, p_sdpmpx = 1'b0, p_sdrmpx1 = 1'b0, p_sdpmpx1 = 1'b0;
    logic [10:0] p_sdr_pad = '0, p_sdr_pad1 = '0;
    logic [12:0] p_sdp_pad = '0, p_sdp_pad1 = '0;

    wire [10:0] sdr_pad  = {sdrad_oe, sdra_l, sdrad_o};
    wire [12:0] sdp_pad  = {sdpad_oe, sdpa, sdpad_o};
    wire [10:0] sdr_pad1 = {sdrad_oe1, sdra_l1, sdrad_o1};
    wire [12:0] sdp_pad1 = {sdpad_oe1, sdpa1, sdpad_o1};

    always @(negedge clk) begin
        if (mon_en) begin
            chk("oe_overlap", int'(!nsdroe && !nsdpoe), 0);
            chk("sdr_padoe_vs_noe", int'(sdrad_oe && !nsdroe), 0);
            chk("sdp_padoe_vs_noe", int'(sdpad_oe && !nsdpoe), 0);
            chk("oe_overlap_1", int'(!nsdroe1 && !nsdpoe1), 0);
            if (sdrmpx != p_sdrmpx)   chk("sdr_pad_stable", int'(sdr_pad), int'(p_sdr_pad));
            if (sdpmpx != p_sdpmpx)   chk("sdp_pad_stable", int'(sdp_pad), int'(p_sdp_pad));
            if (sdrmpx1 != p_sdrmpx1) chk("sdr_pad_stable_1", int'(sdr_pad1), int'(p_sdr_pad1));
            if (sdpmpx1 != p_sdpmpx1) chk("sdp_pad_stable_1", int'(sdp_pad1), int'(p_sdp_pad1));
            if (sdrmpx && !p_sdrmpx)   sdr_lo  = int'({sdra_l, sdrad_o});
            if (!sdrmpx && p_sdrmpx)   sdr_hi  = int'({sdra_l, sdrad_o});
            if (sdpmpx && !p_sdpmpx)   sdp_lo  = int'({sdpa, sdpad_o});
            if (!sdpmpx && p_sdpmpx)   sdp_hi  = int'({sdpa, sdpad_o});
            if (sdpmpx1 && !p_sdpmpx1) sdp1_lo = int'({sdpa1, sdpad_o1});
            if (!sdpmpx1 && p_sdpmpx1) sdp1_hi = int'({sdpa1, sdpad_o1});
            if (sel_chk_en) begin
                if (cur_bus)
                    chk("sdr_idle_while_sdp", int'({sdrmpx, nsdroe, sdrad_oe, sdra_l, sdrad_o, sdra_u}), 32768);
                else
                    chk("sdp_idle_while_sdr", int'({sdpmpx, nsdpoe, sdpad_oe, sdpa, sdpad_o}), 8192);
            end
        end
        p_sdrmpx   = sdrmpx;
        p_sdpmpx   = sdpmpx;
        p_sdrmpx1  = sdrmpx1;
        p_sdpmpx1  = sdpmpx1;
        p_sdr_pad  = sdr_pad;
        p_sdp_pad  = sdp_pad;
        p_sdr_pad1 = sdr_pad1;
        p_sdp_pad1 = sdp_pad1;
    end

    // One request on the default instance; lat counts edges from the accept
    // edge up to the cycle where RSP_VALID is seen.
    task automatic run_txn(input logic bus, input logic [23:0] addr, input logic [7:0] rom,
                           output int lat, output logic [7:0] data, output logic [3:0] u);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        if (!req_ready) chk("ready_timeout", 0, 1);
        sdr_lo = -1; sdr_hi = -1; sdp_lo = -1; sdp_hi = -1;
        cur_bus  = bus;
        req_bus  = bus;
        req_addr = addr;
        sdrad_i  = bus ? ~rom : rom;
        sdpad_i  = bus ? rom : ~rom;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 60) begin step(); lat++; end
        data = rsp_data;
        u    = sdra_u;
    endtask

    typedef struct {
        logic        bus;
        logic [23:0] addr;
        logic [7:0]  rom;
        logic [11:0] lo;
        logic [11:0] hi;
        logic [3:0]  u;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, n, gap_last, accepts, saw;
        logic [7:0] data;
        logic [3:0] u;
        logic take;

        vecs[0] = '{1'b0, 24'h0A53C7, 8'h5A, 12'h3C7, 12'h294, 4'h0};
        vecs[1] = '{1'b1, 24'hFEDCBA, 8'h3E, 12'hCBA, 12'hFED, 4'h0};
        vecs[2] = '{1'b0, 24'hA253C7, 8'h81, 12'h3C7, 12'h094, 4'hA};
        vecs[3] = '{1'b0, 24'hFFFFFF, 8'hFF, 12'h3FF, 12'h3FF, 4'hF};
        vecs[4] = '{1'b1, 24'h000001, 8'h00, 12'h001, 12'h000, 4'h0};
        vecs[5] = '{1'b0, 24'h000400, 8'h11, 12'h000, 12'h001, 4'h0};

        // reset state
        step(); step();
        chk("ready_in_reset", int'(req_ready), 0);
        chk("rsp_valid_in_reset", int'(rsp_valid), 0);
        rst = 1'b0;
        step();
        chk("ready_after_reset", int'(req_ready), 1);
        chk("rsp_data_after_reset", int'(rsp_data), 0);
        chk("sdr_idle_after_reset", int'({sdrmpx, nsdroe, sdrad_oe, sdra_l, sdrad_o, sdra_u}), 32768);
        chk("sdp_idle_after_reset", int'({sdpmpx, nsdpoe, sdpad_oe, sdpa, sdpad_o}), 8192);
        mon_en = 1'b1;
        sel_chk_en = 1'b1;

        // table-driven transactions
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].bus, vecs[i].addr, vecs[i].rom, lat, data, u);
            chk($sformatf("latency[%0d]", i), lat, 14);
            chk($sformatf("rsp_data[%0d]", i), int'(data), int'(vecs[i].rom));
            chk($sformatf("sdra_u_at_done[%0d]", i), int'(u), int'(vecs[i].u));
            chk($sformatf("ready_at_done[%0d]", i), int'(req_ready), 0);
            if (vecs[i].bus) begin
                chk($sformatf("demux_lo[%0d]", i), sdp_lo, int'(vecs[i].lo));
                chk($sformatf("demux_hi[%0d]", i), sdp_hi, int'(vecs[i].hi));
            end else begin
                chk($sformatf("demux_lo[%0d]", i), sdr_lo, int'(vecs[i].lo));
                chk($sformatf("demux_hi[%0d]", i), sdr_hi, int'(vecs[i].hi));
            end
            step();
            chk($sformatf("ready_after_done[%0d]", i), int'(req_ready), 1);
            chk($sformatf("rsp_pulse_one_cycle[%0d]", i), int'(rsp_valid), 0);
            chk($sformatf("rsp_data_held[%0d]", i), int'(rsp_data), int'(vecs[i].rom));
            chk($sformatf("sdra_u_idle[%0d]", i), int'(sdra_u), 0);
        end

        // back-to-back alternating buses with REQ_VALID held high
        sel_chk_en = 1'b0;
        req_bus = 1'b0;
        req_addr = 24'h123456;
        req_valid = 1'b1;
        accepts = 0;
        gap_last = 0;
        n = 0;
        while (accepts < 4 && n < 100) begin
            take = req_ready;
            step();
            n++;
            if (take) begin
                if (accepts > 0) chk($sformatf("b2b_gap[%0d]", accepts), n - gap_last, 15);
                gap_last = n;
                accepts++;
                req_bus = ~req_bus;
                req_addr = req_addr + 24'h010101;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", accepts, 4);
        n = 0;
        while (!req_ready && n < 40) begin step(); n++; end
        chk("b2b_drain", int'(req_ready), 1);

        // reset during READ of an SDR request
        req_bus = 1'b0;
        req_addr = 24'h0F00F0;
        sdrad_i = 8'h77;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (nsdroe && n < 30) begin step(); n++; end
        chk("abort_reached_read", int'(nsdroe), 0);
        step();
        rst = 1'b1;
        step();
        chk("abort_noe", int'(nsdroe), 1);
        chk("abort_mpx", int'(sdrmpx), 0);
        chk("abort_padoe", int'(sdrad_oe), 0);
        chk("abort_addr", int'({sdra_l, sdrad_o, sdra_u}), 0);
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_ready_in_reset", int'(req_ready), 0);
        rst = 1'b0;
        step();
        chk("abort_ready_after", int'(req_ready), 1);
        chk("abort_rsp_data", int'(rsp_data), 0);
        saw = 0;
        for (int k = 0; k < 16; k++) begin
            if (rsp_valid) saw = 1;
            step();
        end
        chk("abort_no_rsp", saw, 0);

        // PHASE_CYC=1, OE_CYC=1 instance: SDP read
        sdp1_lo = -1;
        sdp1_hi = -1;
        req_bus = 1'b1;
        req_addr = 24'h123456;
        sdpad_i = 8'hC3;
        sdrad_i = 8'h3C;
        chk("fast_ready", int'(req_ready1), 1);
        req_valid1 = 1'b1;
        step();
        req_valid1 = 1'b0;
        lat = 1;
        while (!rsp_valid1 && lat < 30) begin step(); lat++; end
        chk("fast_latency", lat, 7);
        chk("fast_rsp_data", int'(rsp_data1), 8'hC3);
        chk("fast_demux_lo", sdp1_lo, 12'h456);
        chk("fast_demux_hi", sdp1_hi, 12'h123);
        step();
        chk("fast_ready_after", int'(req_ready1), 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
